// File: rtl/instrumented_adder_driver.sv
// Host-side sequencer for the instrumented Kogge-Stone adder: accepts one operand pair,
// runs one timed measurement and returns the captured sum, count and timeout flag.
module instrumented_adder_driver #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 32,
   parameter int SETTLE    = 2,
   parameter int TIMEOUT   = 1024
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [WIDTH-1:0]     req_a,
   input  logic [WIDTH-1:0]     req_b,
   input  logic                 req_ext,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [WIDTH-1:0]     resp_sum,
   output logic [CNT_WIDTH-1:0] resp_count,
   output logic                 resp_timeout,
   output logic [WIDTH-1:0]     add_a,
   output logic [WIDTH-1:0]     add_b,
   output logic                 add_ext,
   output logic                 add_run,
   input  logic                 add_done,
   input  logic [WIDTH-1:0]     add_sum,
   input  logic [CNT_WIDTH-1:0] add_count
);

   localparam int MAXC = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_RESP} state_t;

   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic                   req_ready_q;
   logic                   resp_valid_q;
   logic [WIDTH-1:0]       resp_sum_q;
   logic [CNT_WIDTH-1:0]   resp_count_q;
   logic                   resp_timeout_q;
   logic [WIDTH-1:0]       add_a_q;
   logic [WIDTH-1:0]       add_b_q;
   logic                   add_ext_q;
   logic                   add_run_q;

   // One counter serves both phases: settle countdown, then the RUN timeout countdown.
   // In RUN a done sample takes priority over an expiring timeout.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         req_ready_q    <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_sum_q     <= '0;
         resp_count_q   <= '0;
         resp_timeout_q <= 1'b0;
         add_a_q        <= '0;
         add_b_q        <= '0;
         add_ext_q      <= 1'b0;
         add_run_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid && req_ready_q) begin
                  add_a_q     <= req_a;
                  add_b_q     <= req_b;
                  add_ext_q   <= req_ext;
                  cnt_q       <= CW'(SETTLE - 1);
                  req_ready_q <= 1'b0;
                  state_q     <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt_q == '0) begin
                  cnt_q     <= CW'(TIMEOUT - 1);
                  add_run_q <= 1'b1;
                  state_q   <= S_RUN;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_RUN: begin
               if (add_done || cnt_q == '0) begin
                  resp_sum_q     <= add_sum;
                  resp_count_q   <= add_count;
                  resp_timeout_q <= !add_done;
                  resp_valid_q   <= 1'b1;
                  add_run_q      <= 1'b0;
                  state_q        <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready    = req_ready_q;
   assign resp_valid   = resp_valid_q;
   assign resp_sum     = resp_sum_q;
   assign resp_count   = resp_count_q;
   assign resp_timeout = resp_timeout_q;
   assign add_a        = add_a_q;
   assign add_b        = add_b_q;
   assign add_ext      = add_ext_q;
   assign add_run      = add_run_q;

endmodule

// File: tb/tb_instrumented_adder_driver.sv
// Bench for instrumented_adder_driver: two instances (SETTLE=2/TIMEOUT=8 and SETTLE=1/TIMEOUT=4)
// against a small behavioural adder model, with a response scoreboard per instance.
module tb_instrumented_adder_driver;

   logic clk;
   logic rst;

   logic        reqValid[2], reqReady[2], reqExt[2];
   logic        respValid[2], respReady[2], respTimeout[2];
   logic        addExt[2], addRun[2], addDone[2];
   logic [31:0] reqA[2], reqB[2], respSum[2], respCount[2];
   logic [31:0] addA[2], addB[2], addSum[2], addCount[2];

   int          runCycles[2];
   int          doneAt[2];
   logic        doneTie[2];
   logic [31:0] freeCnt;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] sum;
      logic [31:0] count;
      logic        to;
   } respT;

   respT sb0[$];
   respT sb1[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        ext;
      int          dAt;
      logic [31:0] sum;
      logic [31:0] cnt;
      logic        to;
      int          run;
      int          stall;
   } vecT;

   vecT vecs[5];

   instrumented_adder_driver #(.WIDTH(32), .CNT_WIDTH(32), .SETTLE(2), .TIMEOUT(8)) dut0 (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .req_valid(reqValid[0]), .req_ready(reqReady[0]),
      .req_a(reqA[0]), .req_b(reqB[0]), .req_ext(reqExt[0]),
      .resp_valid(respValid[0]), .resp_ready(respReady[0]),
      .resp_sum(respSum[0]), .resp_count(respCount[0]), .resp_timeout(respTimeout[0]),
      .add_a(addA[0]), .add_b(addB[0]), .add_ext(addExt[0]), .add_run(addRun[0]),
      .add_done(addDone[0]), .add_sum(addSum[0]), .add_count(addCount[0])
   );

   instrumented_adder_driver #(.WIDTH(32), .CNT_WIDTH(32), .SETTLE(1), .TIMEOUT(4)) dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .req_valid(reqValid[1]), .req_ready(reqReady[1]),
      .req_a(reqA[1]), .req_b(reqB[1]), .req_ext(reqExt[1]),
      .resp_valid(respValid[1]), .resp_ready(respReady[1]),
      .resp_sum(respSum[1]), .resp_count(respCount[1]), .resp_timeout(respTimeout[1]),
      .add_a(addA[1]), .add_b(addB[1]), .add_ext(addExt[1]), .add_run(addRun[1]),
      .add_done(addDone[1]), .add_sum(addSum[1]), .add_count(addCount[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Adder model: counts RUN cycles; outside RUN, sum and count wander so capture timing shows up.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         freeCnt <= 32'h0;
         for (int i = 0; i < 2; i++) runCycles[i] <= 0;
      end else begin
         freeCnt <= freeCnt + 32'h0101_0101;
         for (int i = 0; i < 2; i++) runCycles[i] <= addRun[i] ? runCycles[i] + 1 : 0;
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         addDone[i]  = doneTie[i] || (addRun[i] && doneAt[i] > 0 && runCycles[i] + 1 >= doneAt[i]);
         addSum[i]   = addRun[i] ? addA[i] + addB[i] : freeCnt;
         addCount[i] = addRun[i] ? 32'h12 + 32'(runCycles[i]) : ~freeCnt;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One full transaction on instance i, with timing checks and an optional response stall.
   task automatic runTxn(input int i, input logic [31:0] a, input logic [31:0] b, input logic ext,
                         input int dAt, input logic tie, input logic [31:0] eSum,
                         input logic [31:0] eCnt, input logic eTo, input int expRun, input int stall);
      int   n;
      int   settleExp;
      respT e;
      settleExp  = (i == 0) ? 2 : 1;
      doneAt[i]  = dAt;
      doneTie[i] = tie;
      e.sum = eSum; e.count = eCnt; e.to = eTo;
      if (i == 0) sb0.push_back(e); else sb1.push_back(e);

      n = 0;
      while (!reqReady[i] && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin checkOutput("req_ready wait", 0, 1); return; end
      reqA[i] = a; reqB[i] = b; reqExt[i] = ext; reqValid[i] = 1'b1;
      @(negedge clk);
      reqValid[i] = 1'b0;
      checkOutput("add_a latched", addA[i], a);
      checkOutput("add_b latched", addB[i], b);
      checkOutput("add_ext latched", addExt[i], ext);

      n = 0;
      while (!addRun[i] && n < 50) begin @(negedge clk); n++; end
      checkOutput("edges accept->add_run", n, settleExp);

      n = 0;
      while (addRun[i] && n < 2000) begin n++; @(negedge clk); end
      checkOutput("add_run high cycles", n, expRun);
      checkOutput("resp_valid", respValid[i], 1);

      if ((i == 0 ? sb0.size() : sb1.size()) == 0) begin
         checkOutput("scoreboard underflow", 1, 0);
         return;
      end
      e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
      checkOutput("resp_sum", respSum[i], e.sum);
      checkOutput("resp_count", respCount[i], e.count);
      checkOutput("resp_timeout", respTimeout[i], e.to);

      for (int s = 0; s < stall; s++) begin
         if (s == 0) begin
            reqA[i] = 32'hFFFF_FFFF; reqB[i] = 32'h1; reqExt[i] = 1'b0; reqValid[i] = 1'b1;
         end
         respReady[i] = 1'b0;
         @(negedge clk);
         checkOutput("stall resp_sum", respSum[i], e.sum);
         checkOutput("stall resp_count", respCount[i], e.count);
         checkOutput("stall resp_valid", respValid[i], 1);
         checkOutput("stall req_ready", reqReady[i], 0);
         checkOutput("stall add_a held", addA[i], a);
      end
      respReady[i] = 1'b1;
      @(negedge clk);
      respReady[i] = 1'b0;
      checkOutput("resp_valid after handshake", respValid[i], 0);
      checkOutput("req_ready after handshake", reqReady[i], 1);
      checkOutput("add_a kept after handshake", addA[i], a);
   endtask

   task automatic applyStimulus();
      for (int k = 0; k < 5; k++)
         runTxn(0, vecs[k].a, vecs[k].b, vecs[k].ext, vecs[k].dAt, 1'b0,
                vecs[k].sum, vecs[k].cnt, vecs[k].to, vecs[k].run, vecs[k].stall);
   endtask

   initial begin
      vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 3, 32'h0000_0008, 32'h14, 1'b0, 3, 0};
      vecs[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1, 32'h2345_6789, 32'h12, 1'b0, 1, 5};
      vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2, 32'h0000_0000, 32'h13, 1'b0, 2, 0};
      vecs[3] = '{32'hA5A5_0000, 32'h0000_5A5A, 1'b1, 0, 32'hA5A5_5A5A, 32'h19, 1'b1, 8, 0};
      vecs[4] = '{32'h0000_0007, 32'h0000_0009, 1'b0, 8, 32'h0000_0010, 32'h19, 1'b0, 8, 0};

      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         reqValid[i] = 1'b0; reqExt[i] = 1'b0; respReady[i] = 1'b0;
         reqA[i] = '0; reqB[i] = '0; doneAt[i] = 0; doneTie[i] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checkOutput("reset req_ready", reqReady[i], 0);
         checkOutput("reset resp_valid", respValid[i], 0);
         checkOutput("reset add_run", addRun[i], 0);
         checkOutput("reset add_a", addA[i], 0);
         checkOutput("reset resp_sum", respSum[i], 0);
      end
      rst = 1'b0;
      @(negedge clk);
      checkOutput("req_ready after reset", reqReady[0], 1);

      applyStimulus();

      // Asynchronous reset while the measurement is running drops the transaction.
      doneAt[0] = 0;
      reqA[0] = 32'h55; reqB[0] = 32'h66; reqValid[0] = 1'b1;
      @(negedge clk);
      reqValid[0] = 1'b0;
      for (int n = 0; n < 20 && !addRun[0]; n++) @(negedge clk);
      checkOutput("add_run before reset", addRun[0], 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async add_run", addRun[0], 0);
      checkOutput("async resp_valid", respValid[0], 0);
      checkOutput("async add_a", addA[0], 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("req_ready after mid-run reset", reqReady[0], 1);
      runTxn(0, 32'h1, 32'h1, 1'b0, 2, 1'b0, 32'h2, 32'h13, 1'b0, 2, 0);

      // Done arriving on the last timeout cycle, then back-to-back immediate-done requests.
      runTxn(1, 32'h100, 32'h200, 1'b1, 4, 1'b0, 32'h300, 32'h15, 1'b0, 4, 0);
      runTxn(1, 32'h2, 32'h3, 1'b0, 0, 1'b1, 32'h5, 32'h12, 1'b0, 1, 0);
      runTxn(1, 32'hA, 32'h14, 1'b1, 0, 1'b1, 32'h1E, 32'h12, 1'b0, 1, 0);

      checkOutput("scoreboard drained", 64'(sb0.size() + sb1.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got hang, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
